// File: rtl/vmask_pkg.sv
// Shared types and helpers for the vmask_gen mask-stream generator.
package vmask_pkg;

  typedef enum logic {
    VMG_IDLE = 1'b0,
    VMG_RUN  = 1'b1
  } vmg_state_e;

  // Beat-index width: enough to hold ceil((2^cnt_w - 1) / 2^dw_bits) plus one
  // spare bit so the index one past the last beat still fits.
  function automatic int beat_idx_w(input int cnt_w, input int dw_bits);
    return cnt_w - dw_bits + 1;
  endfunction

endpackage

// File: rtl/vmask_therm.sv
// Thermometer encoder: input n in [0, DATA_WIDTH] -> low n bits set.
module vmask_therm #(
  parameter int DATA_WIDTH      = 64,
  parameter int DATA_WIDTH_BITS = 6
) (
  input  logic [DATA_WIDTH_BITS:0] i_n,
  output logic [DATA_WIDTH-1:0]    o_therm
);

  // Bit i is set when i lies below the bound.
  always_comb begin
    o_therm = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      o_therm[i] = ((DATA_WIDTH_BITS + 1)'(i) < i_n);
    end
  end

endmodule

// File: rtl/vmask_gen.sv
// vmask_gen: turns an element count (and optional start index) into a stream
// of DATA_WIDTH-bit mask beats, one bit per element.
// Optional feature macro: VMASK_GEN_VSTART_EN adds the in_vstart port; without
// it every request starts at element 0.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  VMG_IDLE | no request held; in_ready high (outside reset)
//  VMG_RUN  | beats being emitted; leaves when the last beat is consumed
module vmask_gen
  import vmask_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int DATA_WIDTH_BITS = 6,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CNT_WIDTH-1:0]     in_count,
`ifdef VMASK_GEN_VSTART_EN
  input  logic [CNT_WIDTH-1:0]     in_vstart,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_mask,
  output logic                     out_last,
  output logic [DATA_WIDTH_BITS:0] out_pop
);

  localparam int BIDX_W = beat_idx_w(CNT_WIDTH, DATA_WIDTH_BITS);
  localparam int AW     = CNT_WIDTH + 1;
  localparam logic [AW-1:0]              DW_A = AW'(DATA_WIDTH);
  localparam logic [DATA_WIDTH_BITS:0]   DW_N = (DATA_WIDTH_BITS + 1)'(DATA_WIDTH);

  vmg_state_e r_state;
  vmg_state_e w_state_nxt;

  logic [AW-1:0]              r_count;
  logic [AW-1:0]              r_vstart;
  logic [BIDX_W-1:0]          r_beat;
  logic                       r_valid;
  logic                       r_last;
  logic [DATA_WIDTH-1:0]      r_mask;
  logic [DATA_WIDTH_BITS:0]   r_pop;

  logic                       w_accept;
  logic                       w_consume;
  logic                       w_advance;
  logic [AW-1:0]              w_vstart_in;
  logic [AW-1:0]              w_cnt_src;
  logic [AW-1:0]              w_vs_src;
  logic [BIDX_W-1:0]          w_beat_src;
  logic [AW-1:0]              w_base;
  logic [AW-1:0]              w_base_end;
  logic [DATA_WIDTH_BITS:0]   w_hi;
  logic [DATA_WIDTH_BITS:0]   w_lo;
  logic [DATA_WIDTH-1:0]      w_therm_hi;
  logic [DATA_WIDTH-1:0]      w_therm_lo;
  logic [DATA_WIDTH-1:0]      w_mask_nxt;
  logic [DATA_WIDTH_BITS:0]   w_pop_nxt;
  logic                       w_last_nxt;

`ifdef VMASK_GEN_VSTART_EN
  assign w_vstart_in = {1'b0, in_vstart};
`else
  assign w_vstart_in = '0;
`endif

  assign in_ready  = (r_state == VMG_IDLE) && !rst;
  assign w_accept  = in_valid && in_ready;
  assign w_consume = r_valid && out_ready;
  assign w_advance = w_consume && !r_last;

  // The next beat comes either from the request being accepted (beat 0) or
  // from the latched request (beat r_beat+1); only one can happen per cycle.
  assign w_cnt_src  = w_accept ? {1'b0, in_count} : r_count;
  assign w_vs_src   = w_accept ? w_vstart_in      : r_vstart;
  assign w_beat_src = w_accept ? '0               : r_beat + 1'b1;

  // Element range of the next beat in CNT_WIDTH+1 arithmetic so the top beat
  // of a maximal count does not wrap.
  assign w_base     = {w_beat_src, DATA_WIDTH_BITS'(0)};
  assign w_base_end = w_base + DW_A;

  // Clamp the count and vstart bounds into the beat-local range [0, DATA_WIDTH].
  always_comb begin
    w_hi = '0;
    w_lo = '0;
    if (w_cnt_src >= w_base_end)   w_hi = DW_N;
    else if (w_cnt_src > w_base)   w_hi = (DATA_WIDTH_BITS + 1)'(w_cnt_src - w_base);
    if (w_vs_src >= w_base_end)    w_lo = DW_N;
    else if (w_vs_src > w_base)    w_lo = (DATA_WIDTH_BITS + 1)'(w_vs_src - w_base);
  end

  vmask_therm #(
    .DATA_WIDTH      (DATA_WIDTH),
    .DATA_WIDTH_BITS (DATA_WIDTH_BITS)
  ) u_therm_hi (
    .i_n     (w_hi),
    .o_therm (w_therm_hi)
  );

  vmask_therm #(
    .DATA_WIDTH      (DATA_WIDTH),
    .DATA_WIDTH_BITS (DATA_WIDTH_BITS)
  ) u_therm_lo (
    .i_n     (w_lo),
    .o_therm (w_therm_lo)
  );

  assign w_mask_nxt = w_therm_hi & ~w_therm_lo;

  // An empty range (count 0 or vstart past count) collapses to one zero beat.
  assign w_last_nxt = (w_cnt_src == '0) || (w_vs_src >= w_cnt_src) ||
                      (w_base_end >= w_cnt_src);

  // Popcount of the next mask, registered alongside it.
  always_comb begin
    w_pop_nxt = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      w_pop_nxt = w_pop_nxt + (DATA_WIDTH_BITS + 1)'(w_mask_nxt[i]);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= VMG_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      VMG_IDLE: if (w_accept)            w_state_nxt = VMG_RUN;
      VMG_RUN:  if (w_consume && r_last) w_state_nxt = VMG_IDLE;
      default:                           w_state_nxt = VMG_IDLE;
    endcase
  end

  // Request latch, beat counter and registered beat outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_vstart <= '0;
      r_beat   <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_mask   <= '0;
      r_pop    <= '0;
    end else if (w_accept) begin
      r_count  <= w_cnt_src;
      r_vstart <= w_vs_src;
      r_beat   <= '0;
      r_valid  <= 1'b1;
      r_last   <= w_last_nxt;
      r_mask   <= w_mask_nxt;
      r_pop    <= w_pop_nxt;
    end else if (w_advance) begin
      r_beat   <= w_beat_src;
      r_last   <= w_last_nxt;
      r_mask   <= w_mask_nxt;
      r_pop    <= w_pop_nxt;
    end else if (w_consume) begin
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_mask   <= '0;
      r_pop    <= '0;
    end
  end

  assign out_valid = r_valid;
  assign out_mask  = r_mask;
  assign out_last  = r_last;
  assign out_pop   = r_pop;

endmodule

// File: tb/tb_vmask_gen.sv
// Testbench for vmask_gen: directed cases plus randomized requests checked
// against an element-range model of the mask stream.
module tb_vmask_gen;

  localparam int DW  = 64;
  localparam int DWB = 6;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_count;
`ifdef VMASK_GEN_VSTART_EN
  logic [CW-1:0] in_vstart;
`endif
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_mask;
  logic          out_last;
  logic [DWB:0]  out_pop;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vmask_gen #(
    .DATA_WIDTH      (DW),
    .DATA_WIDTH_BITS (DWB),
    .CNT_WIDTH       (CW)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_count  (in_count),
`ifdef VMASK_GEN_VSTART_EN
    .in_vstart (in_vstart),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mask  (out_mask),
    .out_last  (out_last),
    .out_pop   (out_pop)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: elements vs..cnt-1 are active; beat b covers b*DW..b*DW+DW-1.
  function automatic int exp_beats(input int cnt, input int vs);
    if (cnt == 0 || vs >= cnt) return 1;
    return (cnt + DW - 1) / DW;
  endfunction

  function automatic logic [63:0] exp_mask(input int cnt, input int vs, input int b);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < DW; i++) begin
      int e;
      e = b * DW + i;
      if (e >= vs && e < cnt) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic int exp_pop(input int cnt, input int vs, input int b);
    int lo, hi;
    lo = (vs > b * DW) ? vs : b * DW;
    hi = (cnt < (b + 1) * DW) ? cnt : (b + 1) * DW;
    return (hi > lo) ? hi - lo : 0;
  endfunction

  // mode 0: out_ready always high; 1: random; 2: low for the first 5 cycles.
  task automatic run_req(input int cnt, input int vs, input int mode, input bit hold_valid);
    int  vs_eff, nb, b, cyc, lim;
    bit  rdy;
`ifdef VMASK_GEN_VSTART_EN
    vs_eff = vs;
`else
    vs_eff = 0 * vs;
`endif
    nb = exp_beats(cnt, vs_eff);
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_count = cnt[CW-1:0];
`ifdef VMASK_GEN_VSTART_EN
    in_vstart = vs[CW-1:0];
`endif
    @(negedge clk);
    if (hold_valid) in_count = in_count ^ 16'h0155;
    else            in_valid = 1'b0;
    b   = 0;
    cyc = 0;
    lim = nb * 20 + 40;
    while (b < nb) begin
      if (cyc >= lim) begin
        chk("beat_timeout", b, nb);
        break;
      end
      chk("out_valid", out_valid, 1'b1);
      chk("out_mask",  out_mask,  exp_mask(cnt, vs_eff, b));
      chk("out_pop",   out_pop,   exp_pop(cnt, vs_eff, b));
      chk("out_last",  out_last,  (b == nb - 1));
      chk("busy_in_ready", in_ready, 1'b0);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 1) == 1);
        default: rdy = (cyc >= 5);
      endcase
      out_ready = rdy;
      cyc++;
      @(negedge clk);
      if (rdy) b++;
    end
    in_valid = 1'b0;
    chk("done_out_valid", out_valid, 1'b0);
    chk("done_in_ready",  in_ready,  1'b1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_count  = '0;
`ifdef VMASK_GEN_VSTART_EN
    in_vstart = '0;
`endif
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_mask",  out_mask,  64'h0);
    chk("rst_out_last",  out_last,  1'b0);
    chk("rst_out_pop",   out_pop,   7'd0);
    chk("rst_in_ready",  in_ready,  1'b0);
    rst = 1'b0;

    // Directed cases.
    run_req(130, 0, 0, 1'b0);
    run_req(0,   0, 0, 1'b0);
    run_req(64,  0, 2, 1'b0);
    run_req(640, 0, 1, 1'b1);
    run_req(65535, 0, 0, 1'b0);
`ifdef VMASK_GEN_VSTART_EN
    run_req(100, 70, 0, 1'b0);
    run_req(130, 200, 1, 1'b0);
`endif

    // Reset in the middle of a 300-element request, then a fresh request.
    @(negedge clk);
    chk("pre_rst_in_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_count = 16'd300;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_beat2_mask", out_mask, exp_mask(300, 0, 2));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_mask",  out_mask,  64'h0);
    chk("mid_rst_out_pop",   out_pop,   7'd0);
    chk("mid_rst_out_last",  out_last,  1'b0);
    chk("mid_rst_in_ready",  in_ready,  1'b0);
    rst = 1'b0;
    run_req(5, 0, 0, 1'b0);

    // Randomized requests.
    for (int n = 0; n < 40; n++) begin
      int sel, cnt, vs;
      sel = $urandom_range(0, 9);
      if (sel == 0)      cnt = 0;
      else if (sel == 1) cnt = 64 * $urandom_range(1, 8);
      else               cnt = $urandom_range(1, 600);
      vs = $urandom_range(0, cnt + 70);
      run_req(cnt, vs, $urandom_range(0, 1), ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
